// File: rtl/t07_imem_responder_if.sv
// Read-only instruction-memory bus between the fetch responder (master)
// and external memory (slave).
interface t07_imem_responder_if;
    logic        bus_read;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    modport master (
        output bus_read, bus_addr, bus_sel,
        input  bus_ack, bus_err, bus_rdata
    );

    modport slave (
        input  bus_read, bus_addr, bus_sel,
        output bus_ack, bus_err, bus_rdata
    );
endinterface

// File: rtl/t07_imem_responder.sv
// Instruction fetch responder: turns single-cycle fetch requests into one
// external bus read, with alignment check, timeout and flush abort.
module t07_imem_responder #(
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_req,
    input  logic [31:0]                 fetch_addr,
    input  logic                        flush,
    t07_imem_responder_if.master        bus,
    output logic [31:0]                 ExtInstruction,
    output logic                        busy_o,
    output logic                        busy_o_edge,
    output logic                        fetch_err
);

    localparam int          TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST  = TW'(TIMEOUT - 1);
    localparam logic [31:0] BADWORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t        stateQ;
    logic [TW-1:0] timerQ;
    logic          busReadQ;
    logic [31:0]   busAddrQ;
    logic [3:0]    busSelQ;
    logic [31:0]   instrQ;
    logic          busyQ;
    logic          edgeQ;
    logic          errQ;

    assign bus.bus_read   = busReadQ;
    assign bus.bus_addr   = busAddrQ;
    assign bus.bus_sel    = busSelQ;
    assign ExtInstruction = instrQ;
    assign busy_o         = busyQ;
    assign busy_o_edge    = edgeQ;
    assign fetch_err      = errQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= IDLE;
            timerQ   <= '0;
            busReadQ <= 1'b0;
            busAddrQ <= '0;
            busSelQ  <= 4'h0;
            instrQ   <= BADWORD;
            busyQ    <= 1'b0;
            edgeQ    <= 1'b0;
            errQ     <= 1'b0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (fetch_req) begin
                        if (fetch_addr[1:0] == 2'b00) begin
                            stateQ   <= BUS;
                            timerQ   <= '0;
                            busReadQ <= 1'b1;
                            busAddrQ <= fetch_addr;
                            busSelQ  <= 4'hF;
                            busyQ    <= 1'b1;
                        end else begin
                            stateQ <= RESP;
                            instrQ <= BADWORD;
                            edgeQ  <= 1'b1;
                            errQ   <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    // Flush beats a same-cycle ack/err; error beats ack; timeout only without either.
                    if (flush) begin
                        stateQ   <= IDLE;
                        busReadQ <= 1'b0;
                        busSelQ  <= 4'h0;
                        busyQ    <= 1'b0;
                    end else if (bus.bus_err || bus.bus_ack || (timerQ == LAST)) begin
                        stateQ   <= RESP;
                        busReadQ <= 1'b0;
                        busSelQ  <= 4'h0;
                        busyQ    <= 1'b0;
                        edgeQ    <= 1'b1;
                        if (bus.bus_err || !bus.bus_ack) begin
                            instrQ <= BADWORD;
                            errQ   <= 1'b1;
                        end else begin
                            instrQ <= bus.bus_rdata;
                        end
                    end else begin
                        timerQ <= timerQ + 1'b1;
                    end
                end
                RESP: begin
                    stateQ <= IDLE;
                    edgeQ  <= 1'b0;
                    errQ   <= 1'b0;
                end
                default: begin
                    stateQ <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t07_imem_responder.sv
// Self-checking bench for t07_imem_responder: a scoreboard queue of expected
// responses is filled by the scenario tasks and drained on busy_o_edge.
module tb_t07_imem_responder;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        flush;
    logic [31:0] ExtInstruction;
    logic        busy_o;
    logic        busy_o_edge;
    logic        fetch_err;

    int    assertCount = 0;
    int    failCount   = 0;
    resp_t expQ[$];

    t07_imem_responder_if busIf ();

    t07_imem_responder #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .flush          (flush),
        .bus            (busIf.master),
        .ExtInstruction (ExtInstruction),
        .busy_o         (busy_o),
        .busy_o_edge    (busy_o_edge),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy_o_edge) begin
                assertCount++;
                if (expQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL sb_unexpected_edge: got edge with data %h, required no response", ExtInstruction);
                end else begin
                    resp_t e;
                    e = expQ.pop_front();
                    if (ExtInstruction !== e.data || fetch_err !== e.err) begin
                        failCount++;
                        $display("[TB] FAIL sb_response: got data %h err %b, required data %h err %b",
                                 ExtInstruction, fetch_err, e.data, e.err);
                    end
                end
            end else begin
                assertCount++;
                if (fetch_err !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL sb_err_without_edge: got fetch_err %b, required 0", fetch_err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pushExp(input logic [31:0] d, input logic e);
        resp_t r;
        r.data = d;
        r.err  = e;
        expQ.push_back(r);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        assertCount++; if (busIf.bus_read !== 1'b0)   begin failCount++; $display("[TB] FAIL rst_bus_read: got %b required 0", busIf.bus_read); end
        assertCount++; if (busIf.bus_addr !== 32'h0)  begin failCount++; $display("[TB] FAIL rst_bus_addr: got %h required 0", busIf.bus_addr); end
        assertCount++; if (busIf.bus_sel !== 4'h0)    begin failCount++; $display("[TB] FAIL rst_bus_sel: got %h required 0", busIf.bus_sel); end
        assertCount++; if (busy_o !== 1'b0)           begin failCount++; $display("[TB] FAIL rst_busy: got %b required 0", busy_o); end
        assertCount++; if (busy_o_edge !== 1'b0)      begin failCount++; $display("[TB] FAIL rst_edge: got %b required 0", busy_o_edge); end
        assertCount++; if (fetch_err !== 1'b0)        begin failCount++; $display("[TB] FAIL rst_fetch_err: got %b required 0", fetch_err); end
        assertCount++; if (ExtInstruction !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL rst_instr: got %h required deadbeef", ExtInstruction); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_aligned_fetch(input logic [31:0] addr, input logic [31:0] rdata);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        step();
        fetch_req  = 1'b0;
        assertCount++; if (busIf.bus_read !== 1'b1 || busIf.bus_addr !== addr || busIf.bus_sel !== 4'hF || busy_o !== 1'b1)
            begin failCount++; $display("[TB] FAIL fetch_issue: got read %b addr %h sel %h busy %b, required 1 %h f 1", busIf.bus_read, busIf.bus_addr, busIf.bus_sel, busy_o, addr); end
        step();
        assertCount++; if (busIf.bus_read !== 1'b1 || busIf.bus_addr !== addr || busy_o_edge !== 1'b0)
            begin failCount++; $display("[TB] FAIL fetch_hold: got read %b addr %h edge %b, required 1 %h 0", busIf.bus_read, busIf.bus_addr, busy_o_edge, addr); end
        busIf.bus_ack   = 1'b1;
        busIf.bus_rdata = rdata;
        pushExp(rdata, 1'b0);
        step();
        busIf.bus_ack = 1'b0;
        assertCount++; if (busy_o_edge !== 1'b1 || busIf.bus_read !== 1'b0 || busIf.bus_sel !== 4'h0 || busy_o !== 1'b0)
            begin failCount++; $display("[TB] FAIL fetch_done: got edge %b read %b sel %h busy %b, required 1 0 0 0", busy_o_edge, busIf.bus_read, busIf.bus_sel, busy_o); end
        step();
        assertCount++; if (busy_o_edge !== 1'b0 || ExtInstruction !== rdata)
            begin failCount++; $display("[TB] FAIL fetch_after: got edge %b instr %h, required 0 %h", busy_o_edge, ExtInstruction, rdata); end
    endtask

    task automatic test_misaligned();
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0102;
        pushExp(32'hDEADBEEF, 1'b1);
        step();
        fetch_addr = 32'h0000_0600;
        assertCount++; if (busIf.bus_read !== 1'b0 || busy_o_edge !== 1'b1 || fetch_err !== 1'b1 || busy_o !== 1'b0)
            begin failCount++; $display("[TB] FAIL misaligned_resp: got read %b edge %b err %b busy %b, required 0 1 1 0", busIf.bus_read, busy_o_edge, fetch_err, busy_o); end
        step();
        fetch_req = 1'b0;
        assertCount++; if (busIf.bus_read !== 1'b0 || busy_o_edge !== 1'b0 || fetch_err !== 1'b0)
            begin failCount++; $display("[TB] FAIL resp_req_ignored: got read %b edge %b err %b, required 0 0 0", busIf.bus_read, busy_o_edge, fetch_err); end
        step();
    endtask

    task automatic test_timeout();
        int n = 0;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0200;
        pushExp(32'hDEADBEEF, 1'b1);
        step();
        fetch_req = 1'b0;
        while (busIf.bus_read === 1'b1 && n < 20) begin
            n++;
            step();
        end
        assertCount++; if (n != TO) begin failCount++; $display("[TB] FAIL timeout_len: got %0d cycles required %0d", n, TO); end
        assertCount++; if (busy_o_edge !== 1'b1 || fetch_err !== 1'b1)
            begin failCount++; $display("[TB] FAIL timeout_resp: got edge %b err %b, required 1 1", busy_o_edge, fetch_err); end
        step();
    endtask

    task automatic test_bus_err();
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0240;
        step();
        fetch_req       = 1'b0;
        busIf.bus_ack   = 1'b1;
        busIf.bus_err   = 1'b1;
        busIf.bus_rdata = 32'h1111_1111;
        pushExp(32'hDEADBEEF, 1'b1);
        step();
        busIf.bus_ack = 1'b0;
        busIf.bus_err = 1'b0;
        assertCount++; if (busy_o_edge !== 1'b1 || ExtInstruction !== 32'hDEADBEEF)
            begin failCount++; $display("[TB] FAIL ack_err_both: got edge %b instr %h, required 1 deadbeef", busy_o_edge, ExtInstruction); end
        step();
    endtask

    task automatic test_flush();
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0300;
        step();
        fetch_req = 1'b0;
        step();
        busIf.bus_ack   = 1'b1;
        busIf.bus_rdata = 32'h1234_5678;
        flush           = 1'b1;
        step();
        busIf.bus_ack = 1'b0;
        flush         = 1'b0;
        assertCount++; if (busy_o_edge !== 1'b0 || busIf.bus_read !== 1'b0 || busy_o !== 1'b0 || ExtInstruction !== 32'hCAFE0013)
            begin failCount++; $display("[TB] FAIL flush_abort: got edge %b read %b busy %b instr %h, required 0 0 0 cafe0013", busy_o_edge, busIf.bus_read, busy_o, ExtInstruction); end
        fetch_req  = 1'b1;
        flush      = 1'b1;
        fetch_addr = 32'h0000_0304;
        step();
        fetch_req = 1'b0;
        flush     = 1'b0;
        assertCount++; if (busIf.bus_read !== 1'b1 || busIf.bus_addr !== 32'h0000_0304 || busy_o !== 1'b1)
            begin failCount++; $display("[TB] FAIL idle_flush_accept: got read %b addr %h busy %b, required 1 304 1", busIf.bus_read, busIf.bus_addr, busy_o); end
        busIf.bus_ack   = 1'b1;
        busIf.bus_rdata = 32'h0040_0113;
        pushExp(32'h0040_0113, 1'b0);
        step();
        busIf.bus_ack = 1'b0;
        step();
    endtask

    task automatic test_back_to_back_reset();
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0400;
        step();
        fetch_addr = 32'h0000_0500;
        step();
        fetch_req = 1'b0;
        assertCount++; if (busIf.bus_addr !== 32'h0000_0400 || busIf.bus_read !== 1'b1)
            begin failCount++; $display("[TB] FAIL bus_req_ignored: got addr %h read %b, required 400 1", busIf.bus_addr, busIf.bus_read); end
        rst = 1'b1;
        #1;
        assertCount++; if (busIf.bus_read !== 1'b0 || busIf.bus_addr !== 32'h0 || busIf.bus_sel !== 4'h0 || busy_o !== 1'b0 || busy_o_edge !== 1'b0 || fetch_err !== 1'b0 || ExtInstruction !== 32'hDEADBEEF)
            begin failCount++; $display("[TB] FAIL async_reset: got read %b addr %h sel %h busy %b edge %b err %b instr %h", busIf.bus_read, busIf.bus_addr, busIf.bus_sel, busy_o, busy_o_edge, fetch_err, ExtInstruction); end
        step();
        rst             = 1'b0;
        busIf.bus_ack   = 1'b1;
        busIf.bus_rdata = 32'h7777_7777;
        step();
        busIf.bus_ack = 1'b0;
        assertCount++; if (busy_o_edge !== 1'b0 || busIf.bus_read !== 1'b0 || ExtInstruction !== 32'hDEADBEEF)
            begin failCount++; $display("[TB] FAIL late_ack_ignored: got edge %b read %b instr %h, required 0 0 deadbeef", busy_o_edge, busIf.bus_read, ExtInstruction); end
        step();
    endtask

    initial begin
        rst             = 1'b1;
        fetch_req       = 1'b0;
        fetch_addr      = 32'h0;
        flush           = 1'b0;
        busIf.bus_ack   = 1'b0;
        busIf.bus_err   = 1'b0;
        busIf.bus_rdata = 32'h0;

        test_reset();
        test_aligned_fetch(32'h0000_0100, 32'h0050_0093);
        test_misaligned();
        test_timeout();
        test_aligned_fetch(32'h0000_0104, 32'hDEADBEEF);
        test_bus_err();
        test_aligned_fetch(32'h0000_0108, 32'hCAFE0013);
        test_flush();
        test_back_to_back_reset();

        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL sb_drained: got %0d pending responses, required 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
